uart_wb_master: RTL and testbench

- Wishbone classic master that sits directly upstream of the UART core's Wishbone slave port. It generates the wb_adr_i/wb_dat_i/wb_we_i/wb_stb_i/wb_cyc_i/wb_sel_i stimulus for that port and consumes wb_ack_o/wb_dat_o.
- Host-side commands enter through a valid/ready request port and are buffered in a small FIFO.
- Each command is executed as one single-beat Wishbone cycle, protected by a timeout.
- Results are returned on a valid/ready response port.

---
 rtl/uart_wb_master_if.sv | 42 ++++
 rtl/uart_wb_master.sv | 182 ++++++++++++++++++
 tb/tb_uart_wb_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_master_if.sv
// Host request/response and Wishbone bus bundle for uart_wb_master.
// The master modport is the DUT view; slave is the host + UART side.
interface uart_wb_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_we;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  modport master (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready,
    output rsp_valid, rsp_we, rsp_data, rsp_err,
    input  rsp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready,
    input  rsp_valid, rsp_we, rsp_data, rsp_err,
    output rsp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/uart_wb_master.sv
// Wishbone classic master feeding the UART register port.
// Queues host commands, runs one single-beat cycle each, with timeout.
module uart_wb_master #(
  parameter int          DEPTH   = 4,
  parameter int          TIMEOUT = 64,
  parameter logic [3:0]  SEL_VAL = 4'b0001
) (
  input logic             clk,
  input logic             wb_rst_i,
  uart_wb_master_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    CYCLE,
    RESP
  } state_t;

  state_t        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q;
  logic          full, empty;
  logic          push, pop;

  logic          we_q;
  logic [2:0]    adr_q;
  logic [7:0]    dat_q;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          rsp_we_q, rsp_we_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          cyc;
  logic          rsp_vld;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

  // req_ready stays low during reset and rises one edge after release.
  assign bus.req_ready = rdy_q && !full;
  assign push = bus.req_valid && bus.req_ready;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers, count and ready gate.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rdy_q  <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {bus.req_we, bus.req_addr, bus.req_data};
    end
  end

  // Transaction sequencing and response capture.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tmo_d      = tmo_q;
    rsp_we_d   = rsp_we_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          tmo_d   = '0;
          state_d = CYCLE;
        end
      end
      CYCLE: begin
        if (bus.wb_ack_i) begin
          rsp_we_d   = we_q;
          rsp_data_d = we_q ? 8'h00 : bus.wb_dat_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_we_d   = we_q;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, timeout counter and response registers.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      rsp_we_q   <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rsp_we_q   <= rsp_we_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Latch the popped command for the duration of the bus cycle.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q  <= 1'b0;
      adr_q <= 3'd0;
      dat_q <= 8'h00;
    end else if (pop) begin
      we_q  <= head.we;
      adr_q <= head.addr;
      dat_q <= head.data;
    end
  end

  // Bus and response outputs decode straight from state so reset
  // clears them without waiting for a clock.
  assign cyc     = (state_q == CYCLE);
  assign rsp_vld = (state_q == RESP);

  assign bus.wb_cyc_o = cyc;
  assign bus.wb_stb_o = cyc;
  assign bus.wb_we_o  = cyc && we_q;
  assign bus.wb_adr_o = cyc ? adr_q : 3'd0;
  assign bus.wb_dat_o = (cyc && we_q) ? dat_q : 8'h00;
  assign bus.wb_sel_o = cyc ? SEL_VAL : 4'b0000;

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_we    = rsp_vld && rsp_we_q;
  assign bus.rsp_data  = rsp_vld ? rsp_data_q : 8'h00;
  assign bus.rsp_err   = rsp_vld && rsp_err_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed testbench for uart_wb_master.
// Behavioural UART slave with selectable ack behaviour.
module tb_uart_wb_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // 0: never ack, 1: ack one cycle after stb, 2: ack held high
  int         ack_mode = 1;
  logic       ack_r;
  logic [7:0] regs [8];

  uart_wb_master_if bus();

  uart_wb_master #(
    .DEPTH(4),
    .TIMEOUT(64),
    .SEL_VAL(4'b0001)
  ) dut (
    .clk(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.wb_ack_i = (ack_mode == 2) ? 1'b1 : ack_r;
  assign bus.wb_dat_i = regs[bus.wb_adr_o];

  // Slave register file and ack generation.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else begin
      if (ack_mode == 1) ack_r <= bus.wb_cyc_o && bus.wb_stb_o && !ack_r;
      else               ack_r <= 1'b0;
      if (bus.wb_cyc_o && bus.wb_ack_i && bus.wb_we_o)
        regs[bus.wb_adr_o] <= bus.wb_dat_o;
    end
  end

  task automatic push(input logic we, input logic [2:0] a,
                      input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_data  = d;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_wait: req_ready got %b expected 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic we, output logic [7:0] d,
                         output logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid got %b expected 1", bus.rsp_valid);
    end
    we = bus.rsp_we;
    d  = bus.rsp_data;
    e  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.wb_cyc_o, bus.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 000",
               {bus.req_ready, bus.wb_cyc_o, bus.rsp_valid});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_held: got %b expected 0", bus.req_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rel: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_write_read();
    logic we;
    logic [7:0] d;
    logic e;
    ack_mode = 1;
    push(1'b1, 3'd3, 8'h83);
    push(1'b0, 3'd3, 8'hFF);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o,
         bus.wb_dat_o, bus.wb_sel_o} !== {3'b111, 3'd3, 8'h83, 4'b0001}) begin
      errors++;
      $display("FAIL wr_bus: cyc/stb/we/adr/dat/sel got %b %b %b %h %h %b expected 1 1 1 3 83 0001",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o,
               bus.wb_dat_o, bus.wb_sel_o);
    end
    get_rsp(we, d, e);
    checks++;
    if ({we, d, e} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL wr_rsp: we/data/err got %b %h %b expected 1 00 0",
               we, d, e);
    end
    get_rsp(we, d, e);
    checks++;
    if ({we, d, e} !== {1'b0, 8'h83, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp: we/data/err got %b %h %b expected 0 83 0",
               we, d, e);
    end
  endtask

  task automatic test_latency();
    logic we;
    logic [7:0] d;
    logic e;
    ack_mode = 2;
    push(1'b0, 3'd3, 8'h00);
    checks++;
    if (bus.wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL lat_accept_edge: cyc got %b expected 0", bus.wb_cyc_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL lat_rise: cyc/stb/rsp_valid got %b expected 110",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.rsp_data}
        !== {3'b001, 8'h83}) begin
      errors++;
      $display("FAIL lat_fall: cyc/stb/rsp_valid/data got %b %h expected 001 83",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid}, bus.rsp_data);
    end
    ack_mode = 1;
    get_rsp(we, d, e);
  endtask

  task automatic test_timeout();
    logic we;
    logic [7:0] d;
    logic e;
    int n;
    int k;
    ack_mode = 0;
    push(1'b0, 3'd1, 8'h00);
    push(1'b1, 3'd2, 8'h44);
    n = bus.wb_cyc_o ? 1 : 0;
    k = 0;
    while (bus.wb_cyc_o && k < 200) begin
      @(posedge clk);
      #1;
      if (bus.wb_cyc_o) n++;
      k++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL tmo_len: cyc cycles got %0d expected 64", n);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b11, 8'h00}) begin
      errors++;
      $display("FAIL tmo_rsp: valid/err/data got %b %b %h expected 1 1 00",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    ack_mode = 1;
    get_rsp(we, d, e);
    get_rsp(we, d, e);
    checks++;
    if ({we, d, e} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL tmo_next: we/data/err got %b %h %b expected 1 00 0",
               we, d, e);
    end
  endtask

  task automatic test_backpressure();
    logic we;
    logic [7:0] d;
    logic e;
    logic [7:0] exp_d [5];
    logic       exp_w [5];
    logic       stuck;
    exp_w[0] = 1'b1; exp_d[0] = 8'h00;
    exp_w[1] = 1'b1; exp_d[1] = 8'h00;
    exp_w[2] = 1'b1; exp_d[2] = 8'h00;
    exp_w[3] = 1'b0; exp_d[3] = 8'h11;
    exp_w[4] = 1'b0; exp_d[4] = 8'h22;
    ack_mode = 1;
    bus.rsp_ready = 1'b0;
    push(1'b1, 3'd4, 8'h11);
    push(1'b1, 3'd5, 8'h22);
    push(1'b1, 3'd6, 8'h33);
    push(1'b0, 3'd4, 8'h00);
    push(1'b0, 3'd5, 8'h00);
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL bp_full: req_ready/rsp_valid got %b expected 01",
               {bus.req_ready, bus.rsp_valid});
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd7;
    bus.req_data  = 8'hEE;
    stuck = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.req_ready) stuck = 1'b1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL bp_reject: req_ready seen got %b expected 0", stuck);
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(we, d, e);
      checks++;
      if ({we, d, e} !== {exp_w[i], exp_d[i], 1'b0}) begin
        errors++;
        $display("FAIL bp_rsp%0d: we/data/err got %b %h %b expected %b %h 0",
                 i, we, d, e, exp_w[i], exp_d[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_drain: cyc/rsp_valid got %b expected 00",
               {bus.wb_cyc_o, bus.rsp_valid});
    end
  endtask

  task automatic test_rsp_stall();
    logic we;
    logic [7:0] d;
    logic e;
    int n;
    ack_mode = 1;
    push(1'b1, 3'd5, 8'h5A);
    get_rsp(we, d, e);
    push(1'b0, 3'd5, 8'h00);
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    push(1'b1, 3'd6, 8'h66);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_data,
           bus.wb_cyc_o} !== {3'b100, 8'h5A, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: valid/we/err/data/cyc got %b %b %b %h %b expected 1 0 0 5a 0",
                 i, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_data,
                 bus.wb_cyc_o);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: rsp_valid got %b expected 0", bus.rsp_valid);
    end
    get_rsp(we, d, e);
    checks++;
    if ({we, d, e} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL stall_next: we/data/err got %b %h %b expected 1 00 0",
               we, d, e);
    end
  endtask

  task automatic test_reset_mid();
    logic we;
    logic [7:0] d;
    logic e;
    logic seen;
    ack_mode = 0;
    push(1'b0, 3'd1, 8'h00);
    push(1'b1, 3'd2, 8'h01);
    push(1'b1, 3'd3, 8'h02);
    checks++;
    if (bus.wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: cyc got %b expected 1", bus.wb_cyc_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err,
         bus.rsp_data, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
         bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o} !== 30'd0) begin
      errors++;
      $display("FAIL rstmid_outs: rdy/rv/rwe/rerr/rdat/cyc/stb/we/adr/dat/sel got %b %b %b %b %h %b %b %b %h %h %b expected all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err,
               bus.rsp_data, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
               bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_mode = 1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b expected 1", bus.req_ready);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wb_cyc_o || bus.rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: activity got %b expected 0", seen);
    end
    push(1'b0, 3'd4, 8'h00);
    get_rsp(we, d, e);
    checks++;
    if ({we, d, e} !== {1'b0, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_new: we/data/err got %b %h %b expected 0 11 0",
               we, d, e);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.wb_cyc_o || bus.rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_empty: activity got %b expected 0", seen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 3'd0;
    bus.req_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_latency();
    test_timeout();
    test_backpressure();
    test_rsp_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
